foo_arbiter: RTL and testbench
==============================

// Module: foo_arbiter
// PURPOSE
//  Shares one foo key-match unit among N_CLIENTS requesters.
//  - Grants one client at a time, round-robin.
//  - Holds foo_req/foo_req_key stable until foo_ack or timeout.
//  - Returns a one-cycle done pulse (plus error flag) to the granted client.
//  - Sits between the client logic and the single foo instance.
// PARAMETERS
//  N_CLIENTS  4   number of requesters, >=2
//  KEY_W      4   key width; must equal the foo key width
//  MAX_WAIT   16  foo_req cycles before timeout; >= foo counter period
// PORTS
//  clk          in   1              clock; all logic on posedge
//  rst          in   1              synchronous reset, active-high
//  cli_req      in   N_CLIENTS      per-client request; hold high until cli_done
//  cli_key      in   N_CLIENTS*KEY_W  client i key at [i*KEY_W +: KEY_W]
//  cli_done     out  N_CLIENTS      one-cycle completion pulse to the granted client
//  cli_err      out  N_CLIENTS      valid with cli_done: 1 = timeout, 0 = matched
//  busy         out  1              transaction in flight (state != IDLE)
//  foo_req      out  1              request to foo
//  foo_req_key  out  KEY_W          key presented to foo
//  foo_ack      in   1              foo match (combinational in foo)
// BEHAVIOUR
//  Reset
//   - state=IDLE, rr_ptr=0, wait_cnt=0, grant_idx=0, key_q=0.
//   - All outputs 0.
//   - An in-flight transaction is dropped: no done pulse is issued.
//  States
//   - IDLE
//     - If any cli_req is high, choose the first requesting index searching
//       rr_ptr, rr_ptr+1, ..., wrapping mod N_CLIENTS.
//     - Latch grant_idx and key_q = cli_key[grant_idx]; clear wait_cnt; go to ISSUE.
//     - If no request, stay in IDLE.
//   - ISSUE
//     - foo_req=1 and foo_req_key=key_q, both driven from registers and
//       constant for the whole state.
//     - foo_ack=1: set hit=1, go to RESP.
//     - Else if wait_cnt==MAX_WAIT-1: set hit=0, go to RESP.
//     - Else wait_cnt++.
//     - wait_cnt width is $clog2(MAX_WAIT+1); it never wraps.
//   - RESP
//     - foo_req=0.
//     - cli_done[grant_idx]=1 and cli_err[grant_idx]=!hit for exactly one cycle;
//       all other bits are 0.
//     - rr_ptr = (grant_idx+1) mod N_CLIENTS; go to IDLE.
//  Latency
//   - cli_req seen in IDLE at cycle t: foo_req is high from t+1.
//   - foo_ack at cycle t+1+k: cli_done at t+2+k.
//   - Minimum request-to-done is 2 cycles; maximum is MAX_WAIT+1.
//   - Minimum turnaround between grants is 3 cycles (IDLE, ISSUE, RESP).
//  Boundary rules
//   - cli_key is sampled only at grant; later key changes are ignored.
//   - cli_req dropping during ISSUE/RESP is ignored; done still pulses.
//   - A cli_req still high in the IDLE cycle after done is a new request.
//   - A requester is never starved: wait is at most N_CLIENTS-1 grants.
//   - foo_ack outside ISSUE is ignored.
//   - foo_ack and the timeout in the same cycle: ack wins (err=0).
//   - busy = (state != IDLE).
// TESTING
//  1 Single client, bench foo model
//    - Stimulus: cli_req[1]=1, key 4'h3; foo_ack asserted in the 3rd ISSUE cycle.
//    - Required: foo_req_key=3 for 3 cycles; cli_done[1] one cycle later;
//      cli_err[1]=0; nothing on other bits.
//  2 Fast ack
//    - Stimulus: foo_ack on the first ISSUE cycle.
//    - Required: cli_done 2 cycles after cli_req first seen; busy high 2 cycles.
//  3 Round-robin
//    - Stimulus: cli_req=4'b0101 held (re-raised after each done) from reset.
//    - Required: grant order 0,2,0,2,...
//    - Stimulus: 4'b1111.
//    - Required: order 0,1,2,3,0.
//  4 Timeout
//    - Stimulus: foo_ack tied 0, client 3 requests.
//    - Required: foo_req high exactly 16 cycles; then cli_done[3]=1, cli_err[3]=1.
//  5 Reset mid-transaction
//    - Stimulus: rst asserted in the 5th ISSUE cycle.
//    - Required: foo_req=0 next cycle; no cli_done; next grant goes to
//      lowest requesting index from 0.
//  6 Integration with real foo
//    - Stimulus: each key 0..F in turn.
//    - Required: every key gets done with err=0 within 16 foo_req cycles;
//      ack+timeout tie resolves to err=0.

Source files
------------

// File: rtl/foo_arbiter.sv
// Round-robin arbiter sharing one foo key-match unit among N_CLIENTS requesters.
// Each grant holds foo_req/foo_req_key until foo_ack or a MAX_WAIT-cycle timeout, then pulses done.
module foo_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int KEY_W     = 4,
  parameter int MAX_WAIT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CLIENTS-1:0]       cli_req,
  input  logic [N_CLIENTS*KEY_W-1:0] cli_key,
  output logic [N_CLIENTS-1:0]       cli_done,
  output logic [N_CLIENTS-1:0]       cli_err,
  output logic                       busy,
  output logic                       foo_req,
  output logic [KEY_W-1:0]           foo_req_key,
  input  logic                       foo_ack
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, grant_idx, pick;
  logic [CNT_W-1:0]   wait_cnt;
  logic [KEY_W-1:0]   key_q, key_sel;
  logic               hit, any_req, tmo;
  int                 j;

  // First requester at or after rr_ptr; lower offsets are visited last so they win.
  always_comb begin
    pick = '0;
    j    = 0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_CLIENTS) j = j - N_CLIENTS;
      if (cli_req[j]) pick = IDX_W'(j);
    end
  end

  assign any_req = |cli_req;
  assign key_sel = cli_key[int'(pick)*KEY_W +: KEY_W];
  assign tmo     = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   if (foo_ack || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      wait_cnt  <= '0;
      key_q     <= '0;
      hit       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_idx <= pick;
          key_q     <= key_sel;
          wait_cnt  <= '0;
        end
        // ack has priority over a simultaneous timeout
        ISSUE: begin
          if (foo_ack)  hit <= 1'b1;
          else if (tmo) hit <= 1'b0;
          else          wait_cnt <= wait_cnt + CNT_W'(1);
        end
        RESP: rr_ptr <= (grant_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : grant_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    foo_req     = (state == ISSUE);
    foo_req_key = key_q;
    cli_done    = '0;
    cli_err     = '0;
    for (int g = 0; g < N_CLIENTS; g++) begin
      if (state == RESP && grant_idx == IDX_W'(g)) begin
        cli_done[g] = 1'b1;
        cli_err[g]  = !hit;
      end
    end
  end

endmodule

// File: tb/tb_foo_arbiter.sv
// Directed bench for foo_arbiter: latency, round-robin order, timeout, reset and a foo model.
module tb_foo_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cli_req;
  logic [15:0] cli_key;
  logic [3:0]  cli_done, cli_err;
  logic        busy, foo_req, foo_ack;
  logic [3:0]  foo_req_key;
  logic [3:0]  fcnt;
  int          total = 0, bad = 0;
  int          gidx, nreq, nbusy, lat;
  logic        err;
  logic        model_on = 1'b0;

  foo_arbiter #(.N_CLIENTS(4), .KEY_W(4), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .cli_req(cli_req), .cli_key(cli_key),
    .cli_done(cli_done), .cli_err(cli_err), .busy(busy),
    .foo_req(foo_req), .foo_req_key(foo_req_key), .foo_ack(foo_ack)
  );

  always #5 clk = ~clk;

  // foo stand-in: free-running key counter, matches when it equals the presented key
  always_ff @(posedge clk) fcnt <= rst ? 4'h0 : fcnt + 4'h1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cli_req = '0; foo_ack = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Run one transaction from IDLE; ack on ISSUE cycle ack_cyc (0 = never) unless model_on.
  // Returns in the IDLE cycle after done.
  task automatic txn(input int ack_cyc);
    bit seen;
    seen = 0; gidx = -1; err = 1'b0; nreq = 0; nbusy = 0; lat = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (foo_req) nreq++;
      if (busy) nbusy++;
      foo_ack = model_on ? (foo_req && fcnt == foo_req_key) : (foo_req && nreq == ack_cyc);
      if (cli_done != 4'b0) begin
        seen = 1;
        chk("done_onehot", $countones(cli_done), 1);
        chk("err_masked", cli_err & ~cli_done, 0);
        for (int b = 0; b < 4; b++) if (cli_done[b]) gidx = b;
        err = |cli_err;
      end else begin
        tick;
        lat++;
      end
    end
    if (!seen) chk("txn_bound", 0, 1);
    foo_ack = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1; cli_req = '0; cli_key = '0; foo_ack = 1'b0;
    tick; tick;
    chk("rst_done", cli_done, 0);
    chk("rst_err", cli_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_foo_req", foo_req, 0);
    chk("rst_key", foo_req_key, 0);
    rst = 1'b0;

    // ack while idle has no effect
    foo_ack = 1'b1; tick; tick;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_done", cli_done, 0);
    foo_ack = 1'b0;

    // 1: client 1, key 3, ack on 3rd ISSUE cycle; key changed mid-transaction
    cli_key = 16'h0030; cli_req = 4'b0010;
    tick;
    chk("t1_req_c1", foo_req, 1);
    chk("t1_key_c1", foo_req_key, 4'h3);
    cli_key = 16'h00A0;
    tick;
    chk("t1_key_c2", foo_req_key, 4'h3);
    chk("t1_done_early", cli_done, 0);
    tick;
    chk("t1_key_c3", foo_req_key, 4'h3);
    foo_ack = 1'b1;
    tick;
    foo_ack = 1'b0;
    chk("t1_done", cli_done, 4'b0010);
    chk("t1_err", cli_err, 4'b0000);
    chk("t1_req_off", foo_req, 0);
    cli_req = '0;
    tick;
    chk("t1_done_pulse", cli_done, 0);
    chk("t1_idle", busy, 0);

    // 2: fast ack
    cli_req = 4'b0001;
    txn(1);
    cli_req = '0;
    chk("t2_lat", lat, 2);
    chk("t2_busy", nbusy, 2);
    chk("t2_grant", gidx, 0);
    chk("t2_err", err, 0);

    // 3: round-robin
    do_reset;
    cli_req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      txn(1);
      chk($sformatf("t3a_grant%0d", n), gidx, (n % 2) * 2);
    end
    do_reset;
    cli_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      txn(2);
      chk($sformatf("t3b_grant%0d", n), gidx, n % 4);
    end
    cli_req = '0;

    // 4: timeout, then ack/timeout tie
    tick;
    cli_req = 4'b1000;
    txn(0);
    cli_req = '0;
    chk("t4_nreq", nreq, 16);
    chk("t4_grant", gidx, 3);
    chk("t4_err", err, 1);
    chk("t4_lat", lat, 17);
    cli_req = 4'b0100;
    txn(16);
    cli_req = '0;
    chk("tie_nreq", nreq, 16);
    chk("tie_err", err, 0);

    // 5: reset in 5th ISSUE cycle (rr_ptr currently 3)
    cli_req = 4'b0110;
    tick;
    for (int n = 1; n < 5; n++) tick;
    chk("t5_in_issue", foo_req, 1);
    rst = 1'b1;
    tick;
    chk("t5_req_off", foo_req, 0);
    chk("t5_no_done", cli_done, 0);
    rst = 1'b0;
    cli_req = 4'b1010;
    txn(1);
    cli_req = '0;
    chk("t5_grant", gidx, 1);

    // 6: every key through the foo model
    model_on = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cli_key = '0;
      cli_key[(k % 4) * 4 +: 4] = 4'(k);
      cli_req = 4'b0001 << (k % 4);
      txn(0);
      cli_req = '0;
      chk($sformatf("t6_err_k%0d", k), err, 0);
      chk($sformatf("t6_grant_k%0d", k), gidx, k % 4);
      chk($sformatf("t6_wait_k%0d", k), (nreq >= 1 && nreq <= 16), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
